// File: rtl/sdram_tester_pkg.sv
// Shared definitions for the SDRAM pattern tester: pattern mode codes,
// FSM state encoding and Galois LFSR tap constants per data width.
package sdram_tester_pkg;

  typedef enum logic [1:0] {
    MODE_ADDR = 2'd0,
    MODE_INV  = 2'd1,
    MODE_LFSR = 2'd2,
    MODE_WALK = 2'd3
  } mode_e;

  // Priming/gap/issue states are only entered when the pre-open read is built in.
  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_WR_REQ   = 4'd1,
    ST_WR_WAIT  = 4'd2,
    ST_RD_REQ   = 4'd3,
    ST_RD_WAIT  = 4'd4,
    ST_DONE     = 4'd5,
    ST_PR_WAIT  = 4'd6,
    ST_PR_GAP   = 4'd7,
    ST_RD_ISSUE = 4'd8
  } state_e;

  localparam logic [31:0] LFSR_TAPS_8  = 32'h0000_00B8;
  localparam logic [31:0] LFSR_TAPS_16 = 32'h0000_B400;
  localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;

  // Right-shifting Galois taps for the supported data widths.
  function automatic logic [31:0] lfsr_taps(input int dw);
    case (dw)
      32'sd8:  lfsr_taps = LFSR_TAPS_8;
      32'sd16: lfsr_taps = LFSR_TAPS_16;
      default: lfsr_taps = LFSR_TAPS_32;
    endcase
  endfunction

endpackage

// File: rtl/sdram_pattern_gen.sv
// Pattern source for the SDRAM tester: a registered Galois LFSR (seeded to
// all-ones) plus a combinational mux selecting address, inverted address,
// LFSR or walking-one data for the current word index.
module sdram_pattern_gen
  import sdram_tester_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] w,
  input  logic                  advance,
  input  logic                  reseed,
  output logic [DATA_WIDTH-1:0] pattern
);

  localparam int                    SHW       = $clog2(DATA_WIDTH);
  localparam logic [31:0]           TAPS_FULL = lfsr_taps(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] TAPS      = TAPS_FULL[DATA_WIDTH-1:0];

  logic [DATA_WIDTH-1:0] lfsr_r;

  function automatic logic [DATA_WIDTH-1:0] lfsr_step(input logic [DATA_WIDTH-1:0] v);
    lfsr_step = (v >> 1) ^ (v[0] ? TAPS : {DATA_WIDTH{1'b0}});
  endfunction

  // LFSR state: reseed wins over advance so readback restarts the sequence.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_r <= {DATA_WIDTH{1'b1}};
    end else if (reseed) begin
      lfsr_r <= {DATA_WIDTH{1'b1}};
    end else if (advance) begin
      lfsr_r <= lfsr_step(lfsr_r);
    end else begin
      lfsr_r <= lfsr_r;
    end
  end

  // Expected/written word for the current word index and mode.
  always_comb begin
    pattern = w;
    case (mode_e'(mode))
      MODE_ADDR: pattern = w;
      MODE_INV:  pattern = ~w;
      MODE_LFSR: pattern = lfsr_r;
      MODE_WALK: pattern = {{(DATA_WIDTH-1){1'b0}}, 1'b1} << w[SHW-1:0];
      default:   pattern = w;
    endcase
  end

endmodule

// File: rtl/sdram_pattern_tester.sv
// SDRAM pattern tester: fills [0, last_addr] with a selectable pattern through
// the sdram_ctrl request interface, reads it back and counts mismatches, with
// an ack timeout abort. Optional macro SDRAM_TESTER_PREOPEN_EN adds a priming
// read to {addr[hi:8], 8'hFF} plus a fixed gap before every real read, with
// refresh_inhibit held over that window.
module sdram_pattern_tester
  import sdram_tester_pkg::*;
#(
  parameter int ADDR_WIDTH  = 24,
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_STEP   = 2,
  parameter int TIMEOUT     = 1023,
  parameter int ERR_WIDTH   = 16,
  parameter int PREOPEN_GAP = 30
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [ADDR_WIDTH-1:0] last_addr,
  output logic [ADDR_WIDTH-1:0] sd_addr,
  output logic [DATA_WIDTH-1:0] sd_wr_data,
  input  logic [DATA_WIDTH-1:0] sd_rd_data,
  output logic                  sd_we,
  output logic                  sd_enable,
  input  logic                  sd_ack,
  input  logic                  sd_idle,
  output logic                  refresh_inhibit,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [ERR_WIDTH-1:0]  err_count,
  output logic                  err_strobe,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic [DATA_WIDTH-1:0] err_data
);

`ifdef SDRAM_TESTER_PREOPEN_EN
  localparam bit PREOPEN_EN = 1'b1;
`else
  localparam bit PREOPEN_EN = 1'b0;
`endif

  localparam int STEP_SHIFT = $clog2(ADDR_STEP);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int GW = (PREOPEN_GAP > 1) ? $clog2(PREOPEN_GAP + 1) : 1;
  localparam logic [TW-1:0]         TMO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0]         GAP_LAST   = GW'(PREOPEN_GAP - 1);
  localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(ADDR_STEP);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(ADDR_STEP - 1);
  localparam logic [ERR_WIDTH-1:0]  ERR_MAX    = {ERR_WIDTH{1'b1}};

  state_e                state_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [ADDR_WIDTH-1:0] last_r;
  logic [1:0]            mode_r;
  logic [TW-1:0]         tmr_r;
  logic [GW-1:0]         gap_r;
  logic                  refresh_inh_r;

  logic [DATA_WIDTH-1:0] w_s;
  logic [DATA_WIDTH-1:0] pattern_s;
  logic [ADDR_WIDTH-1:0] prime_addr_s;
  logic                  addr_last_s;
  logic                  tmo_s;
  logic                  mismatch_s;
  logic [ERR_WIDTH-1:0]  err_next_s;
  logic                  advance_s;
  logic                  reseed_s;

  assign w_s             = DATA_WIDTH'(addr_r >> STEP_SHIFT);
  assign prime_addr_s    = {addr_r[ADDR_WIDTH-1:8], 8'hFF};
  assign refresh_inhibit = PREOPEN_EN & refresh_inh_r;

  sdram_pattern_gen #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_gen (
    .clk     (clk),
    .reset   (reset),
    .mode    (mode_r),
    .w       (w_s),
    .advance (advance_s),
    .reseed  (reseed_s),
    .pattern (pattern_s)
  );

  // Word-completion decode: compare, saturating error count, LFSR control.
  always_comb begin
    addr_last_s = (addr_r == last_r);
    tmo_s       = (tmr_r == TMO_LAST);
    if ((state_r == ST_RD_WAIT) && sd_ack) begin
      mismatch_s = (sd_rd_data != pattern_s);
    end else begin
      mismatch_s = 1'b0;
    end
    if (mismatch_s && (err_count != ERR_MAX)) begin
      err_next_s = err_count + ERR_WIDTH'(1);
    end else begin
      err_next_s = err_count;
    end
    advance_s = sd_ack && ((state_r == ST_WR_WAIT) || (state_r == ST_RD_WAIT));
    reseed_s  = ((state_r == ST_IDLE) && start) ||
                ((state_r == ST_WR_WAIT) && sd_ack && addr_last_s);
  end

  // Test sequencer: request handshakes, timeout abort and result reporting.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      addr_r        <= {ADDR_WIDTH{1'b0}};
      last_r        <= {ADDR_WIDTH{1'b0}};
      mode_r        <= 2'd0;
      tmr_r         <= {TW{1'b0}};
      gap_r         <= {GW{1'b0}};
      refresh_inh_r <= 1'b0;
      sd_addr       <= {ADDR_WIDTH{1'b0}};
      sd_wr_data    <= {DATA_WIDTH{1'b0}};
      sd_we         <= 1'b0;
      sd_enable     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      timeout       <= 1'b0;
      err_count     <= {ERR_WIDTH{1'b0}};
      err_strobe    <= 1'b0;
      err_addr      <= {ADDR_WIDTH{1'b0}};
      err_data      <= {DATA_WIDTH{1'b0}};
    end else begin
      done       <= 1'b0;
      err_strobe <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            mode_r    <= mode;
            last_r    <= last_addr & ~ALIGN_MASK;
            addr_r    <= {ADDR_WIDTH{1'b0}};
            err_count <= {ERR_WIDTH{1'b0}};
            err_addr  <= {ADDR_WIDTH{1'b0}};
            err_data  <= {DATA_WIDTH{1'b0}};
            pass      <= 1'b0;
            timeout   <= 1'b0;
            busy      <= 1'b1;
            state_r   <= ST_WR_REQ;
          end
        end
        ST_WR_REQ: begin
          if (sd_idle && !sd_enable) begin
            sd_addr    <= addr_r;
            sd_wr_data <= pattern_s;
            sd_we      <= 1'b1;
            sd_enable  <= 1'b1;
            tmr_r      <= {TW{1'b0}};
            state_r    <= ST_WR_WAIT;
          end
        end
        ST_WR_WAIT: begin
          if (sd_ack) begin
            sd_enable <= 1'b0;
            if (addr_last_s) begin
              addr_r  <= {ADDR_WIDTH{1'b0}};
              state_r <= ST_RD_REQ;
            end else begin
              addr_r  <= addr_r + STEP;
              state_r <= ST_WR_REQ;
            end
          end else if (tmo_s) begin
            sd_enable     <= 1'b0;
            timeout       <= 1'b1;
            pass          <= 1'b0;
            done          <= 1'b1;
            busy          <= 1'b0;
            refresh_inh_r <= 1'b0;
            state_r       <= ST_DONE;
          end else begin
            tmr_r <= tmr_r + TW'(1);
          end
        end
        ST_RD_REQ: begin
          if (sd_idle && !sd_enable) begin
            sd_we     <= 1'b0;
            sd_enable <= 1'b1;
            tmr_r     <= {TW{1'b0}};
            if (PREOPEN_EN) begin
              sd_addr       <= prime_addr_s;
              refresh_inh_r <= 1'b1;
              state_r       <= ST_PR_WAIT;
            end else begin
              sd_addr <= addr_r;
              state_r <= ST_RD_WAIT;
            end
          end
        end
        ST_PR_WAIT: begin
          if (sd_ack) begin
            sd_enable <= 1'b0;
            gap_r     <= {GW{1'b0}};
            state_r   <= ST_PR_GAP;
          end else if (tmo_s) begin
            sd_enable     <= 1'b0;
            timeout       <= 1'b1;
            pass          <= 1'b0;
            done          <= 1'b1;
            busy          <= 1'b0;
            refresh_inh_r <= 1'b0;
            state_r       <= ST_DONE;
          end else begin
            tmr_r <= tmr_r + TW'(1);
          end
        end
        ST_PR_GAP: begin
          if (gap_r == GAP_LAST) begin
            state_r <= ST_RD_ISSUE;
          end else begin
            gap_r <= gap_r + GW'(1);
          end
        end
        ST_RD_ISSUE: begin
          if (sd_idle && !sd_enable) begin
            sd_addr   <= addr_r;
            sd_we     <= 1'b0;
            sd_enable <= 1'b1;
            tmr_r     <= {TW{1'b0}};
            state_r   <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          if (sd_ack) begin
            sd_enable     <= 1'b0;
            refresh_inh_r <= 1'b0;
            err_count     <= err_next_s;
            if (mismatch_s) begin
              err_strobe <= 1'b1;
              err_addr   <= addr_r;
              err_data   <= sd_rd_data;
            end
            if (addr_last_s) begin
              done    <= 1'b1;
              busy    <= 1'b0;
              pass    <= (err_next_s == {ERR_WIDTH{1'b0}}) && !timeout;
              state_r <= ST_DONE;
            end else begin
              addr_r  <= addr_r + STEP;
              state_r <= ST_RD_REQ;
            end
          end else if (tmo_s) begin
            sd_enable     <= 1'b0;
            timeout       <= 1'b1;
            pass          <= 1'b0;
            done          <= 1'b1;
            busy          <= 1'b0;
            refresh_inh_r <= 1'b0;
            state_r       <= ST_DONE;
          end else begin
            tmr_r <= tmr_r + TW'(1);
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          sd_enable     <= 1'b0;
          busy          <= 1'b0;
          refresh_inh_r <= 1'b0;
          state_r       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_pattern_tester.sv
// Directed bench for sdram_pattern_tester: an ideal SDRAM model acking three
// cycles after each request (with optional read corruption and a withheld
// write ack), a protocol monitor, and one task per scenario.
module tb_sdram_pattern_tester;

  localparam int AW  = 24;
  localparam int DW  = 16;
  localparam int TMO = 1023;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [AW-1:0] last_addr = 24'h0;
  logic [AW-1:0] sd_addr;
  logic [DW-1:0] sd_wr_data;
  logic [DW-1:0] sd_rd_data;
  logic          sd_we, sd_enable, sd_ack, sd_idle;
  logic          refresh_inhibit, busy, done, pass, timeout, err_strobe;
  logic [15:0]   err_count;
  logic [AW-1:0] err_addr;
  logic [DW-1:0] err_data;

  int n_cmp = 0;
  int n_fail = 0;

  // memory model / monitor state (written only by the model process)
  logic [DW-1:0] mem [0:1023];
  logic [DW-1:0] wr_log [0:2047];
  logic [DW-1:0] rd_log [0:2047];
  int n_wr = 0, n_rd = 0, n_wrreq = 0, n_done = 0, n_estb = 0, viol = 0;
  int cnt = 0, cur_len = 0, last_len = 0, cur_req_idx = 0;
  logic          prev_en = 1'b0, prev_ack = 1'b0, prev_we = 1'b0;
  logic [AW-1:0] prev_addr = 24'h0;
  logic [DW-1:0] prev_wd = 16'h0;
  logic [AW-1:0] max_wr_addr = 24'h0;

  // model configuration (written only by the test process)
  logic          corrupt_en = 1'b0;
  logic [AW-1:0] corrupt_addr = 24'h0;
  logic          no_ack_en = 1'b0;
  int            no_ack_at = 0;

  // per-test snapshots
  int b_wr, b_rd, b_done, b_estb, b_req;

  sdram_pattern_tester #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ADDR_STEP(2),
    .TIMEOUT(TMO), .ERR_WIDTH(16), .PREOPEN_GAP(30)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .last_addr(last_addr),
    .sd_addr(sd_addr), .sd_wr_data(sd_wr_data), .sd_rd_data(sd_rd_data),
    .sd_we(sd_we), .sd_enable(sd_enable), .sd_ack(sd_ack), .sd_idle(sd_idle),
    .refresh_inhibit(refresh_inhibit), .busy(busy), .done(done), .pass(pass),
    .timeout(timeout), .err_count(err_count), .err_strobe(err_strobe),
    .err_addr(err_addr), .err_data(err_data)
  );

  always #5 clk = ~clk;

  // SDRAM model and protocol monitor, evaluated on the falling edge
  initial begin
    sd_ack = 1'b0;
    sd_rd_data = 16'h0;
    sd_idle = 1'b1;
    forever begin
      @(negedge clk);
      if (done) n_done++;
      if (err_strobe) n_estb++;
      if (prev_ack && sd_enable) viol++;
      if (sd_enable && prev_en &&
          (sd_addr !== prev_addr || sd_wr_data !== prev_wd || sd_we !== prev_we)) viol++;
      if (sd_enable && !prev_en && sd_we) begin
        cur_req_idx = n_wrreq;
        n_wrreq++;
      end
      if (sd_enable) cur_len++;
      else begin
        if (prev_en) last_len = cur_len;
        cur_len = 0;
      end
      if (sd_ack) begin
        sd_ack = 1'b0;
        cnt = 0;
      end else if (sd_enable) begin
        cnt++;
        if (cnt == 3 && !(sd_we && no_ack_en && cur_req_idx == no_ack_at)) begin
          sd_ack = 1'b1;
          if (sd_we) begin
            mem[sd_addr[10:1]] = sd_wr_data;
            wr_log[n_wr] = sd_wr_data;
            n_wr++;
            if (sd_addr > max_wr_addr) max_wr_addr = sd_addr;
          end else begin
            sd_rd_data = mem[sd_addr[10:1]] ^
                         ((corrupt_en && sd_addr == corrupt_addr) ? 16'h0001 : 16'h0000);
            rd_log[n_rd] = sd_rd_data;
            n_rd++;
          end
        end
      end else begin
        cnt = 0;
      end
      prev_en = sd_enable;
      prev_addr = sd_addr;
      prev_wd = sd_wr_data;
      prev_we = sd_we;
      prev_ack = sd_ack;
    end
  end

  task automatic snap();
    b_wr = n_wr; b_rd = n_rd; b_done = n_done; b_estb = n_estb; b_req = n_wrreq;
  endtask

  task automatic wait_done();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (seen !== 1'b1) begin
      n_fail++;
      $display("FAIL done_wait: got done=%b within budget, required 1", seen);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic run_test(input logic [1:0] m, input logic [AW-1:0] la);
    snap();
    mode = m;
    last_addr = la;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({sd_enable, sd_we, busy, done, pass, timeout, err_strobe, refresh_inhibit} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_flags: got %b required 00000000",
               {sd_enable, sd_we, busy, done, pass, timeout, err_strobe, refresh_inhibit});
    end
    n_cmp++;
    if (err_count !== 16'h0 || sd_addr !== 24'h0 || err_addr !== 24'h0 || err_data !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_values: got cnt=%h addr=%h eaddr=%h edata=%h required all 0",
               err_count, sd_addr, err_addr, err_data);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_start_with_reset();
    snap();
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    repeat (6) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || n_wrreq != b_req) begin
      n_fail++;
      $display("FAIL start_with_reset: got busy=%b reqs=%0d required busy=0 reqs=0",
               busy, n_wrreq - b_req);
    end
  endtask

  task automatic test_fill_readback();
    run_test(2'd0, 24'h00001E);
    n_cmp++;
    if (n_wr - b_wr != 16 || n_rd - b_rd != 16) begin
      n_fail++;
      $display("FAIL fill_counts: got wr=%0d rd=%0d required 16/16", n_wr - b_wr, n_rd - b_rd);
    end
    n_cmp++;
    if (pass !== 1'b1 || err_count !== 16'h0 || timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_result: got pass=%b cnt=%h tmo=%b required 1/0000/0", pass, err_count, timeout);
    end
    n_cmp++;
    if (n_done - b_done != 1 || n_estb - b_estb != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_pulses: got done=%0d strobes=%0d busy=%b required 1/0/0",
               n_done - b_done, n_estb - b_estb, busy);
    end
    n_cmp++;
    if (max_wr_addr !== 24'h00001E || wr_log[b_wr + 15] !== 16'h000F) begin
      n_fail++;
      $display("FAIL fill_range: got max=%h w15=%h required 00001e/000f", max_wr_addr, wr_log[b_wr + 15]);
    end
    n_cmp++;
    if (viol != 0) begin
      n_fail++;
      $display("FAIL protocol: got %0d violations required 0", viol);
    end
  endtask

  task automatic test_corrupt();
    corrupt_addr = 24'h00000A;
    corrupt_en = 1'b1;
    run_test(2'd0, 24'h00001E);
    corrupt_en = 1'b0;
    n_cmp++;
    if (n_estb - b_estb != 1 || err_count !== 16'h0001) begin
      n_fail++;
      $display("FAIL corrupt_count: got strobes=%0d cnt=%h required 1/0001", n_estb - b_estb, err_count);
    end
    n_cmp++;
    if (err_addr !== 24'h00000A || err_data !== 16'h0004) begin
      n_fail++;
      $display("FAIL corrupt_capture: got addr=%h data=%h required 00000a/0004", err_addr, err_data);
    end
    n_cmp++;
    if (pass !== 1'b0 || timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL corrupt_pass: got pass=%b tmo=%b required 0/0", pass, timeout);
    end
  endtask

  task automatic test_timeout();
    no_ack_at = n_wrreq + 2;
    no_ack_en = 1'b1;
    run_test(2'd0, 24'h00001E);
    no_ack_en = 1'b0;
    n_cmp++;
    if (last_len != TMO) begin
      n_fail++;
      $display("FAIL timeout_len: got enable high %0d cycles required %0d", last_len, TMO);
    end
    n_cmp++;
    if (timeout !== 1'b1 || pass !== 1'b0 || sd_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_flags: got tmo=%b pass=%b en=%b required 1/0/0", timeout, pass, sd_enable);
    end
    n_cmp++;
    if (n_wr - b_wr != 2 || n_rd - b_rd != 0 || n_done - b_done != 1) begin
      n_fail++;
      $display("FAIL timeout_counts: got wr=%0d rd=%0d done=%0d required 2/0/1",
               n_wr - b_wr, n_rd - b_rd, n_done - b_done);
    end
  endtask

  task automatic test_lfsr();
    int diff;
    run_test(2'd2, 24'h0003FE);
    n_cmp++;
    if (wr_log[b_wr] !== 16'hFFFF || wr_log[b_wr + 1] !== 16'hCBFF || wr_log[b_wr + 2] !== 16'hD1FF) begin
      n_fail++;
      $display("FAIL lfsr_seq: got %h %h %h required ffff cbff d1ff",
               wr_log[b_wr], wr_log[b_wr + 1], wr_log[b_wr + 2]);
    end
    diff = 0;
    for (int k = 0; k < 512; k++) if (rd_log[b_rd + k] !== wr_log[b_wr + k]) diff++;
    n_cmp++;
    if (diff != 0 || n_rd - b_rd != 512) begin
      n_fail++;
      $display("FAIL lfsr_readback: got %0d differing of %0d reads required 0 of 512", diff, n_rd - b_rd);
    end
    n_cmp++;
    if (err_count !== 16'h0 || pass !== 1'b1 || timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL lfsr_result: got cnt=%h pass=%b tmo=%b required 0000/1/0", err_count, pass, timeout);
    end
  endtask

  task automatic test_walk_and_inv();
    run_test(2'd3, 24'h000022);
    n_cmp++;
    if (wr_log[b_wr] !== 16'h0001 || wr_log[b_wr + 15] !== 16'h8000 ||
        wr_log[b_wr + 16] !== 16'h0001 || wr_log[b_wr + 17] !== 16'h0002) begin
      n_fail++;
      $display("FAIL walk_words: got w0=%h w15=%h w16=%h w17=%h required 0001 8000 0001 0002",
               wr_log[b_wr], wr_log[b_wr + 15], wr_log[b_wr + 16], wr_log[b_wr + 17]);
    end
    n_cmp++;
    if (pass !== 1'b1 || n_wr - b_wr != 18) begin
      n_fail++;
      $display("FAIL walk_result: got pass=%b wr=%0d required 1/18", pass, n_wr - b_wr);
    end
    run_test(2'd1, 24'h000006);
    n_cmp++;
    if (wr_log[b_wr] !== 16'hFFFF || wr_log[b_wr + 3] !== 16'hFFFC || pass !== 1'b1) begin
      n_fail++;
      $display("FAIL inv_words: got w0=%h w3=%h pass=%b required ffff fffc 1",
               wr_log[b_wr], wr_log[b_wr + 3], pass);
    end
  endtask

  task automatic test_single_word();
    run_test(2'd0, 24'h000001);
    n_cmp++;
    if (n_wr - b_wr != 1 || n_rd - b_rd != 1 || wr_log[b_wr] !== 16'h0000 || pass !== 1'b1) begin
      n_fail++;
      $display("FAIL single_word: got wr=%0d rd=%0d w0=%h pass=%b required 1/1/0000/1",
               n_wr - b_wr, n_rd - b_rd, wr_log[b_wr], pass);
    end
  endtask

  task automatic test_start_while_busy();
    snap();
    mode = 2'd0;
    last_addr = 24'h00001E;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    mode = 2'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (5) @(negedge clk);
    n_cmp++;
    if (n_wr - b_wr != 16 || wr_log[b_wr + 3] !== 16'h0003 || n_done - b_done != 1 || pass !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_start: got wr=%0d w3=%h done=%0d pass=%b required 16/0003/1/1",
               n_wr - b_wr, wr_log[b_wr + 3], n_done - b_done, pass);
    end
  endtask

  task automatic test_reset_mid_read();
    logic found;
    snap();
    mode = 2'd0;
    last_addr = 24'h00001E;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (sd_enable && !sd_we) begin
        found = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (found !== 1'b1) begin
      n_fail++;
      $display("FAIL reach_rd_wait: got found=%b required 1", found);
    end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (sd_enable !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: got en=%b busy=%b done=%b required 0/0/0", sd_enable, busy, done);
    end
    reset = 1'b0;
    repeat (10) @(negedge clk);
    n_cmp++;
    if (n_done - b_done != 0) begin
      n_fail++;
      $display("FAIL reset_no_done: got %0d done pulses required 0", n_done - b_done);
    end
    run_test(2'd0, 24'h00001E);
    n_cmp++;
    if (n_rd - b_rd != 16 || err_count !== 16'h0 || pass !== 1'b1 || viol != 0) begin
      n_fail++;
      $display("FAIL rerun_after_reset: got rd=%0d cnt=%h pass=%b viol=%0d required 16/0000/1/0",
               n_rd - b_rd, err_count, pass, viol);
    end
  endtask

  initial begin
    test_reset();
    test_start_with_reset();
    test_fill_readback();
    test_corrupt();
    test_timeout();
    test_lfsr();
    test_walk_and_inv();
    test_single_word();
    test_start_while_busy();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
